li_rr_arbiter: RTL and testbench
================================

# li_rr_arbiter

Round-robin arbiter that merges `NUM_IN` latency-insensitive input links onto one output link, sharing a single downstream wrapped pearl (or any `li_link` sink) between several producers. It has one registered output stage and gives fair, starvation-free, one-transfer-per-cycle throughput. Each input is back-pressured through its `stop` signal. Each output word carries the index of the input that supplied it.

## Interface
Parameters:
- `DWIDTH`, 16: data width of all links.
- `NUM_IN`, 4: number of input links; must be ≥2.
- `SRC_W`, `$clog2(NUM_IN)`: width of the source index.
- `MAX_BURST`, 4: maximum consecutive grants to one input. Used only with `LI_ARB_BURST_EN`; must be ≥1.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `reset`  input  1  reset is synchronous and active-high.
- `i_links[NUM_IN]`  `li_link.sink`  DWIDTH  requester links, each with data, valid and stop.
- `o_link`  `li_link.source`  DWIDTH  merged output link.
- `o_src`  output  SRC_W  index of the input whose word is on `o_link.data`; meaningful when `o_link.valid`=1.

## Operation
- Link rule: a word transfers on a cycle with valid=1 and stop=0. While stop=1 and valid=1, the source holds data and valid stable. Valid never depends combinationally on stop.
- Output register: `o_link.valid`, `o_link.data` and `o_src` are flops.
- `load = !o_link.valid || !o_link.stop`.
- When `load` is high, the arbiter picks the first valid input, searching upward from pointer `ptr` and wrapping modulo `NUM_IN`.
  - Grant to input g: the output register takes `i_links[g].data` and g, and `o_link.valid` is set to 1.
  - `load` high with no input valid: `o_link.valid` is set to 0. Data and `o_src` hold their previous values.
  - `load` low: the output register holds and no grant is made.
- Input stop: `i_links[k].stop = !(load && grant==k)`. This is combinational from the input valids, `ptr` and `o_link.stop`. Every non-granted input sees stop=1.
- Pointer update without the burst feature: after a grant to g, `ptr` becomes (g+1) mod `NUM_IN`. With no grant, `ptr` holds.
- Fairness guarantee: a continuously valid input is granted within `NUM_IN` loads.
- Reset (synchronous, also when it arrives mid-operation):
  - `o_link.valid`=0, `o_src`=0, `o_link.data`=0, `ptr`=0, burst count=0.
  - All `i_links[k].stop`=1 while `reset`=1.
  - Any word held in the output register is discarded.

## Timing
- Latency: a word accepted on cycle n appears on `o_link` on cycle n+1.
- Throughput: one word per cycle while `o_link.stop`=0.
- Downstream stall: while `o_link.stop`=1 and `o_link.valid`=1, all inputs see stop=1 and the output word holds.
  - When stop falls on cycle m, the held word transfers on cycle m.
  - A new grant is made on that same cycle m, with no bubble.
- `o_link.stop`=1 while `o_link.valid`=0: `load` is still 1, so the register fills. The word then holds until stop falls.
- Simultaneous requests: all inputs valid gives the grant order `ptr`, `ptr`+1, … with wrap from `NUM_IN`-1 to 0.
- Single requester: the same input is granted every cycle. `ptr` wraps past it each time, which causes no stall.

## Configuration
- `LI_ARB_BURST_EN` defined: a burst counter `bcnt` (width `$clog2(MAX_BURST+1)`) is compiled in.
  - On a grant to g with g equal to the previous grantee, `bcnt` increments; otherwise `bcnt` is set to 1.
  - `ptr` stays at g until `bcnt` reaches `MAX_BURST`. It then moves to (g+1) mod `NUM_IN` and `bcnt` clears.
  - If the burst holder is not valid when `load`=1, the normal search from `ptr` applies, and `bcnt` is set by the new grant.
  - `MAX_BURST`=1 behaves identically to the undefined case.
- `LI_ARB_BURST_EN` undefined: pure per-transfer round-robin. No counter logic exists and `MAX_BURST` is ignored.

## Test plan
- Reset: assert `reset` for 2 cycles with all four inputs valid. Required: `o_link.valid`=0, all stops=1, and after release the first grant goes to input 0 (`o_src`=0).
- All valid, burst undefined, `o_link.stop`=0: inputs carry 0xA000+k. Required output sequence: `o_src` 0,1,2,3,0… with data 0xA000, 0xA001, 0xA002, 0xA003, one per cycle.
- Only input 2 valid (data 0x1234, 0x1235, 0x1236): required output on 3 consecutive cycles with `o_src`=2, and inputs 0, 1 and 3 see stop=1.
- Downstream stall: hold `o_link.stop`=1 for 5 cycles while `o_link.valid`=1. Required: the output word is stable, no input sees stop=0, and when stop falls the next grantee follows on the following cycle with no loss or duplication.
- Burst defined, `MAX_BURST`=3, all valid: required `o_src` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
- Reset mid-stall with valid output 0xBEEF: required `o_link.valid`=0 on the cycle after reset, the word is dropped, and arbitration restarts from input 0.

Source files
------------

// File: rtl/li_rr_arbiter_if.sv
// Latency-insensitive link: a word moves on a cycle with valid=1 and stop=0.
// The source holds data/valid stable while it is stopped.
interface li_link #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              stop;

    modport source (output data, output valid, input stop);
    modport sink   (input data, input valid, output stop);
endinterface : li_link

// File: rtl/li_rr_arbiter.sv
// Round-robin merge of NUM_IN li_link inputs onto one registered output link.
// Optional macro LI_ARB_BURST_EN enables up to MAX_BURST consecutive grants per input.
module li_rr_arbiter #(
    parameter int DWIDTH    = 16,
    parameter int NUM_IN    = 4,
    parameter int SRC_W     = $clog2(NUM_IN),
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    li_link.sink             i_links [NUM_IN],
    li_link.source           o_link,
    output logic [SRC_W-1:0] o_src
);

    localparam logic [SRC_W:0]   L_NUM  = (SRC_W+1)'(NUM_IN);
    localparam logic [SRC_W-1:0] L_LAST = SRC_W'(NUM_IN - 1);

    if (NUM_IN < 2 || MAX_BURST < 1) begin : g_param_check
        $error("li_rr_arbiter: NUM_IN must be >= 2 and MAX_BURST >= 1");
    end

    logic [NUM_IN-1:0] w_valid;
    logic [DWIDTH-1:0] w_data [NUM_IN];
    logic              w_load;
    logic              w_found;
    logic [SRC_W-1:0]  w_gnt;
    logic [SRC_W:0]    w_sum;

    logic              r_valid;
    logic [DWIDTH-1:0] r_data;
    logic [SRC_W-1:0]  r_src;
    logic [SRC_W-1:0]  r_ptr;

    // Successor of an input index, wrapping at NUM_IN-1.
    function automatic logic [SRC_W-1:0] f_next(input logic [SRC_W-1:0] g);
        if (g == L_LAST) begin
            return {SRC_W{1'b0}};
        end else begin
            return g + SRC_W'(1);
        end
    endfunction

    // Unpack the input links; stop is released only to the input granted on a load.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        assign w_valid[k]       = i_links[k].valid;
        assign w_data[k]        = i_links[k].data;
        assign i_links[k].stop  = reset | ~(w_load & w_found & (w_gnt == SRC_W'(k)));
    end

    assign w_load = ~r_valid | ~o_link.stop;

    // Search from r_ptr upward; scanning offsets high-to-low leaves the nearest valid input.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = {SRC_W{1'b0}};
        w_sum   = {(SRC_W+1){1'b0}};
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (SRC_W+1)'(i);
            if (w_sum >= L_NUM) begin
                w_sum = w_sum - L_NUM;
            end else begin
                w_sum = w_sum;
            end
            if (w_valid[w_sum[SRC_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_sum[SRC_W-1:0];
            end else begin
                w_found = w_found;
                w_gnt   = w_gnt;
            end
        end
    end

    // Output register: load a granted word, drop valid on an empty load, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= {DWIDTH{1'b0}};
            r_src   <= {SRC_W{1'b0}};
        end else if (w_load) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_data  <= w_data[w_gnt];
                r_src   <= w_gnt;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef LI_ARB_BURST_EN
    localparam int                L_BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [L_BCNT_W-1:0] L_MAXB = L_BCNT_W'(MAX_BURST);

    logic [L_BCNT_W-1:0] r_bcnt;
    logic [L_BCNT_W-1:0] w_bcnt_inc;

    // A live count with the same grantee extends the burst; any other grant starts at 1.
    always_comb begin
        if ((r_bcnt != {L_BCNT_W{1'b0}}) && (w_gnt == r_src)) begin
            w_bcnt_inc = r_bcnt + L_BCNT_W'(1);
        end else begin
            w_bcnt_inc = L_BCNT_W'(1);
        end
    end

    // Pointer parks on the grantee until its burst is used up, then moves past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= {SRC_W{1'b0}};
            r_bcnt <= {L_BCNT_W{1'b0}};
        end else if (w_load && w_found) begin
            if (w_bcnt_inc >= L_MAXB) begin
                r_ptr  <= f_next(w_gnt);
                r_bcnt <= {L_BCNT_W{1'b0}};
            end else begin
                r_ptr  <= w_gnt;
                r_bcnt <= w_bcnt_inc;
            end
        end
    end
`else
    // Plain round-robin: the pointer moves just past every grantee.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= {SRC_W{1'b0}};
        end else if (w_load && w_found) begin
            r_ptr <= f_next(w_gnt);
        end
    end
`endif

    assign o_link.valid = r_valid;
    assign o_link.data  = r_data;
    assign o_src        = r_src;

endmodule : li_rr_arbiter

// File: tb/tb_li_rr_arbiter.sv
// Randomized and directed bench for li_rr_arbiter against a cycle-level reference model.
module tb_li_rr_arbiter;

    localparam int NUM = 4;
    localparam int MAXB = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [15:0]     tb_data [NUM];
    logic [NUM-1:0]  tb_valid;
    logic            tb_ostop;
    logic [NUM-1:0]  dut_stop;
    logic [1:0]      o_src;
    logic [NUM-1:0]  xfer;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic        m_valid;
    logic [15:0] m_data;
    int          m_src;
    int          m_ptr;
    int          m_prev;
    int          m_cnt;

    li_link #(.DWIDTH(16)) in_if [NUM] ();
    li_link #(.DWIDTH(16)) out_if ();

    for (genvar k = 0; k < NUM; k++) begin : g_drv
        assign in_if[k].data  = tb_data[k];
        assign in_if[k].valid = tb_valid[k];
        assign dut_stop[k]    = in_if[k].stop;
    end
    assign out_if.stop = tb_ostop;

    li_rr_arbiter #(.DWIDTH(16), .NUM_IN(NUM), .MAX_BURST(MAXB)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .i_links (in_if),
        .o_link  (out_if),
        .o_src   (o_src)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check input stops before the edge, advance the model, check the output after.
    task automatic step();
        int             win;
        int             k;
        logic           load;
        logic [NUM-1:0] exp_stop;
        #1;
        load = !m_valid || !tb_ostop;
        win  = -1;
        for (int i = NUM - 1; i >= 0; i--) begin
            k = (m_ptr + i) % NUM;
            if (tb_valid[k]) win = k;
        end
        for (int j = 0; j < NUM; j++) exp_stop[j] = reset || !(load && win == j);
        check_eq("in_stop", {28'h0, dut_stop}, {28'h0, exp_stop});
        xfer = tb_valid & ~exp_stop;
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0; m_data = 16'h0; m_src = 0; m_ptr = 0; m_cnt = 0; m_prev = 0;
        end else if (load) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_data  = tb_data[win];
                m_src   = win;
`ifdef LI_ARB_BURST_EN
                if (win == m_prev && m_cnt > 0) m_cnt = m_cnt + 1;
                else m_cnt = 1;
                m_prev = win;
                if (m_cnt >= MAXB) begin
                    m_ptr = (win + 1) % NUM;
                    m_cnt = 0;
                end else begin
                    m_ptr = win;
                end
`else
                m_ptr = (win + 1) % NUM;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_eq("o_valid", {31'h0, out_if.valid}, {31'h0, m_valid});
        check_eq("o_src", {30'h0, o_src}, m_src);
        check_eq("o_data", {16'h0, out_if.data}, {16'h0, m_data});
    endtask

    logic [15:0] held;
    int          exp_src;

    initial begin
        m_valid = 1'b0; m_data = 16'h0; m_src = 0; m_ptr = 0; m_cnt = 0; m_prev = 0;
        xfer = '0;
        reset = 1'b1;
        tb_ostop = 1'b0;
        tb_valid = 4'hF;
        for (int k = 0; k < NUM; k++) tb_data[k] = 16'hA000 + 16'(k);

        // Reset with all inputs valid, then all-valid round robin
        step(); step();
        check_eq("rst_valid", {31'h0, out_if.valid}, 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 13; c++) begin
            step();
`ifdef LI_ARB_BURST_EN
            exp_src = (c / MAXB) % NUM;
`else
            exp_src = c % NUM;
`endif
            check_eq("seq_src", {30'h0, o_src}, exp_src);
            check_eq("seq_data", {16'h0, out_if.data}, 32'hA000 + exp_src);
        end

        // Single requester: input 2 granted back to back
        tb_valid = 4'b0100;
        tb_data[2] = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("single_src", {30'h0, o_src}, 32'd2);
            check_eq("single_data", {16'h0, out_if.data}, 32'h1234 + c);
            if (xfer[2]) tb_data[2] = tb_data[2] + 16'd1;
        end

        // Downstream stall for 5 cycles while output is valid
        tb_valid = 4'hF;
        for (int k = 0; k < NUM; k++) tb_data[k] = 16'hC000 + 16'(k);
        step();
        held = out_if.data;
        tb_ostop = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("stall_hold", {16'h0, out_if.data}, {16'h0, held});
        end
        tb_ostop = 1'b0;
        step(); step();

        // Randomized traffic with random back-pressure; producers hold while stopped
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NUM; k++) begin
                if (xfer[k] || !tb_valid[k]) begin
                    tb_valid[k] = ($urandom_range(0, 3) != 0);
                    tb_data[k]  = 16'($urandom);
                end
            end
            tb_ostop = ($urandom_range(0, 3) == 0);
            step();
        end

        // Reset while a 0xBEEF word is stalled in the output register
        tb_ostop = 1'b0;
        tb_valid = 4'b0000;
        step();
        tb_valid = 4'b0010;
        tb_data[1] = 16'hBEEF;
        step();
        check_eq("beef_load", {16'h0, out_if.data}, 32'h0000BEEF);
        tb_valid = 4'b0000;
        tb_ostop = 1'b1;
        step();
        reset = 1'b1;
        step();
        check_eq("rst_drop", {31'h0, out_if.valid}, 32'h0);
        reset = 1'b0;
        tb_ostop = 1'b0;
        tb_valid = 4'hF;
        step();
        check_eq("rst_restart", {30'h0, o_src}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_li_rr_arbiter
